// File: rtl/l2_lookup_pipe_pkg.sv
// l2_lookup_pipe_pkg: shared types and Spandex word-state encodings for the L2 lookup pipe
package l2_lookup_pipe_pkg;
    localparam int L2_WAYS  = 8;
    localparam int L2_WORDS = 4;
    localparam logic [2:0] SPX_I = 3'd0;
    localparam logic [2:0] SPX_V = 3'd1;
    localparam logic [2:0] SPX_S = 3'd2;
    localparam logic [2:0] SPX_R = 3'd3;
    typedef logic [$clog2(L2_WAYS)-1:0] l2_way_t;
    typedef logic [L2_WORDS-1:0] word_mask_t;
    typedef enum logic {L2_LOOKUP = 1'b0, L2_LOOKUP_FWD = 1'b1} lookup_mode_t;
endpackage

// File: rtl/l2_lookup_pipe_way_prio_enc.sv
// l2_way_prio_enc: lowest-index priority encoder over a way vector
//   i_vec   : one bit per way
//   o_found : any bit set
//   o_idx   : lowest set index (0 when none)
//   o_multi : more than one bit set
module l2_way_prio_enc #(
    parameter int N = 8,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_vec,
    output logic          o_found,
    output logic [IW-1:0] o_idx,
    output logic          o_multi
);
    always_comb begin
        o_idx = '0;
        for (int i = N - 1; i >= 0; i--) o_idx = i_vec[i] ? IW'(i) : o_idx;
    end
    assign o_found = |i_vec;
    // clearing the lowest set bit leaves something only if two or more were set
    assign o_multi = |(i_vec & (i_vec - N'(1)));
endmodule

// File: rtl/l2_lookup_pipe.sv
// l2_lookup_pipe: one-stage L2 tag/state lookup resolving hit, empty and round-robin victim way
//   clk, rst (async, active-low)
//   i_req_valid/o_req_ready, i_req_mode, i_req_tag, i_req_set, i_tags_in, i_states_in : request side
//   o_resp_valid/i_resp_ready : result handshake
//   o_tag_hit, o_way_hit, o_multi_hit, o_empty_found, o_empty_way, o_evict_way,
//   o_mask_shared, o_mask_owned : registered lookup result
module l2_lookup_pipe
    import l2_lookup_pipe_pkg::*;
#(
    parameter int WAYS    = 8,
    parameter int WORDS   = 4,
    parameter int SETS    = 256,
    parameter int TAG_W   = 20,
    parameter int STATE_W = 3,
    localparam int WW = $clog2(WAYS),
    localparam int SW = $clog2(SETS)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_req_valid,
    output logic                           o_req_ready,
    input  logic                           i_req_mode,
    input  logic [TAG_W-1:0]               i_req_tag,
    input  logic [SW-1:0]                  i_req_set,
    input  logic [WAYS*TAG_W-1:0]          i_tags_in,
    input  logic [WAYS*WORDS*STATE_W-1:0]  i_states_in,
    output logic                           o_resp_valid,
    input  logic                           i_resp_ready,
    output logic                           o_tag_hit,
    output logic [WW-1:0]                  o_way_hit,
    output logic                           o_multi_hit,
    output logic                           o_empty_found,
    output logic [WW-1:0]                  o_empty_way,
    output logic [WW-1:0]                  o_evict_way,
    output logic [WORDS-1:0]               o_mask_shared,
    output logic [WORDS-1:0]               o_mask_owned
);
    logic [WAYS-1:0]  w_present, w_match;
    logic             w_hit, w_multi, w_empty, w_empty_multi_unused;
    logic [WW-1:0]    w_hit_way, w_empty_way, w_ptr;
    logic [WORDS-1:0] w_ms, w_mo;
    logic             w_fwd, w_accept, w_upd;
    logic [WW-1:0]    r_ptr [SETS];
    logic             r_valid, r_hit, r_multi, r_empty;
    lookup_mode_t     r_mode;
    logic [SW-1:0]    r_set;
    logic [WW-1:0]    r_way, r_ew, r_ev;
    logic [WORDS-1:0] r_ms, r_mo;

    always_comb begin
        w_present = '0;
        w_match   = '0;
        for (int i = 0; i < WAYS; i++) begin
            for (int j = 0; j < WORDS; j++)
                w_present[i] = w_present[i] | (i_states_in[(i*WORDS+j)*STATE_W +: STATE_W] != STATE_W'(SPX_I));
            w_match[i] = w_present[i] && (i_tags_in[i*TAG_W +: TAG_W] == i_req_tag);
        end
    end

    l2_way_prio_enc #(.N(WAYS)) u_hit_enc (
        .i_vec   (w_match),
        .o_found (w_hit),
        .o_idx   (w_hit_way),
        .o_multi (w_multi)
    );

    l2_way_prio_enc #(.N(WAYS)) u_empty_enc (
        .i_vec   (~w_present),
        .o_found (w_empty),
        .o_idx   (w_empty_way),
        .o_multi (w_empty_multi_unused)
    );

    always_comb begin
        w_ms = '0;
        w_mo = '0;
        for (int j = 0; j < WORDS; j++) begin
            w_mo[j] = w_hit && (i_states_in[(int'(w_hit_way)*WORDS+j)*STATE_W +: STATE_W] == STATE_W'(SPX_R));
            w_ms[j] = w_hit && (w_mo[j] || i_states_in[(int'(w_hit_way)*WORDS+j)*STATE_W +: STATE_W] == STATE_W'(SPX_S));
        end
    end

    assign o_req_ready = !r_valid || i_resp_ready;
    assign w_accept    = i_req_valid && o_req_ready;
    assign w_fwd       = lookup_mode_t'(i_req_mode) == L2_LOOKUP_FWD;
    assign w_upd       = r_valid && i_resp_ready && r_mode == L2_LOOKUP && !r_hit && !r_empty;
    // a same-set request accepted while the previous victim is handed off must see the advanced pointer
    assign w_ptr       = r_ptr[i_req_set] + ((w_upd && r_set == i_req_set) ? WW'(1) : WW'(0));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < SETS; s++) r_ptr[s] <= '0;
        end else if (w_upd) begin
            r_ptr[r_set] <= r_ptr[r_set] + WW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_mode  <= L2_LOOKUP;
            r_set   <= '0;
            r_hit   <= 1'b0;
            r_way   <= '0;
            r_multi <= 1'b0;
            r_empty <= 1'b0;
            r_ew    <= '0;
            r_ev    <= '0;
            r_ms    <= '0;
            r_mo    <= '0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_mode  <= lookup_mode_t'(i_req_mode);
            r_set   <= i_req_set;
            r_hit   <= w_hit;
            r_way   <= w_hit_way;
            r_multi <= w_multi;
            r_empty <= !w_fwd && w_empty;
            r_ew    <= w_fwd ? '0 : w_empty_way;
            r_ev    <= w_fwd ? '0 : (w_empty ? w_empty_way : w_ptr);
            r_ms    <= w_ms;
            r_mo    <= w_mo;
        end else if (i_resp_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_resp_valid  = r_valid;
    assign o_tag_hit     = r_hit;
    assign o_way_hit     = r_way;
    assign o_multi_hit   = r_multi;
    assign o_empty_found = r_empty;
    assign o_empty_way   = r_ew;
    assign o_evict_way   = r_ev;
    assign o_mask_shared = r_ms;
    assign o_mask_owned  = r_mo;
endmodule

// File: tb/tb_l2_lookup_pipe.sv
// tb_l2_lookup_pipe: random and directed checks of l2_lookup_pipe against a behavioural model
module tb_l2_lookup_pipe;
    import l2_lookup_pipe_pkg::*;
    localparam int WAYS = 8, WORDS = 4, SETS = 256, TAG_W = 20, STATE_W = 3;
    localparam int WW = 3, SW = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic i_req_valid = 1'b0, i_req_mode = 1'b0, i_resp_ready = 1'b0;
    logic [TAG_W-1:0] i_req_tag = '0;
    logic [SW-1:0] i_req_set = '0;
    logic [WAYS*TAG_W-1:0] i_tags_in = '0;
    logic [WAYS*WORDS*STATE_W-1:0] i_states_in = '0;
    logic o_req_ready, o_resp_valid, o_tag_hit, o_multi_hit, o_empty_found;
    logic [WW-1:0] o_way_hit, o_empty_way, o_evict_way;
    logic [WORDS-1:0] o_mask_shared, o_mask_owned;

    always #5 clk = ~clk;

    l2_lookup_pipe #(.WAYS(WAYS), .WORDS(WORDS), .SETS(SETS), .TAG_W(TAG_W), .STATE_W(STATE_W)) dut (
        .clk(clk), .rst(rst),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_mode(i_req_mode),
        .i_req_tag(i_req_tag), .i_req_set(i_req_set), .i_tags_in(i_tags_in), .i_states_in(i_states_in),
        .o_resp_valid(o_resp_valid), .i_resp_ready(i_resp_ready),
        .o_tag_hit(o_tag_hit), .o_way_hit(o_way_hit), .o_multi_hit(o_multi_hit),
        .o_empty_found(o_empty_found), .o_empty_way(o_empty_way), .o_evict_way(o_evict_way),
        .o_mask_shared(o_mask_shared), .o_mask_owned(o_mask_owned)
    );

    int pass_cnt = 0, chk_cnt = 0;
    int ptr [SETS];
    bit m_valid, m_hit, m_multi, m_ef, m_upd;
    int m_way, m_ew, m_ev, m_set;
    logic [WORDS-1:0] m_ms, m_mo;

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    endtask

    function automatic logic [STATE_W-1:0] st(int w, int j);
        return i_states_in[(w*WORDS+j)*STATE_W +: STATE_W];
    endfunction

    task automatic set_word(int w, int j, logic [STATE_W-1:0] s);
        i_states_in[(w*WORDS+j)*STATE_W +: STATE_W] = s;
    endtask

    task automatic model_reset();
        m_valid = 0;
        for (int s = 0; s < SETS; s++) ptr[s] = 0;
    endtask

    task automatic model_step();
        bit acc, ho, pres;
        int hw, hc, ew;
        acc = i_req_valid && (!m_valid || i_resp_ready);
        ho  = m_valid && i_resp_ready;
        if (ho && m_upd) ptr[m_set] = (ptr[m_set] + 1) % WAYS;
        if (acc) begin
            hw = -1; hc = 0; ew = -1;
            for (int w = 0; w < WAYS; w++) begin
                pres = 0;
                for (int j = 0; j < WORDS; j++) if (st(w, j) != SPX_I) pres = 1;
                if (pres && i_tags_in[w*TAG_W +: TAG_W] == i_req_tag) begin
                    hc++;
                    if (hw < 0) hw = w;
                end
                if (!pres && ew < 0) ew = w;
            end
            m_valid = 1;
            m_hit   = hc > 0;
            m_way   = hw < 0 ? 0 : hw;
            m_multi = hc > 1;
            for (int j = 0; j < WORDS; j++) begin
                m_mo[j] = m_hit && st(m_way, j) == SPX_R;
                m_ms[j] = m_hit && (st(m_way, j) == SPX_R || st(m_way, j) == SPX_S);
            end
            m_set = int'(i_req_set);
            m_ef  = !i_req_mode && ew >= 0;
            m_ew  = m_ef ? ew : 0;
            m_ev  = i_req_mode ? 0 : (m_ef ? ew : ptr[m_set]);
            m_upd = !i_req_mode && !m_hit && !m_ef;
        end else if (ho) begin
            m_valid = 0;
        end
    endtask

    task automatic compare();
        chk("req_ready", o_req_ready, !m_valid || i_resp_ready);
        chk("resp_valid", o_resp_valid, m_valid);
        if (m_valid) begin
            chk("tag_hit", o_tag_hit, m_hit);
            chk("way_hit", o_way_hit, m_way);
            chk("multi_hit", o_multi_hit, m_multi);
            chk("empty_found", o_empty_found, m_ef);
            chk("empty_way", o_empty_way, m_ew);
            chk("evict_way", o_evict_way, m_ev);
            chk("mask_shared", o_mask_shared, m_ms);
            chk("mask_owned", o_mask_owned, m_mo);
        end
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare();
    endtask

    task automatic fill_full();
        for (int w = 0; w < WAYS; w++) begin
            i_tags_in[w*TAG_W +: TAG_W] = TAG_W'(32'hF0000 + w);
            for (int j = 0; j < WORDS; j++) set_word(w, j, SPX_V);
        end
    endtask

    task automatic req(bit mode, int tag, int set);
        i_req_valid = 1; i_req_mode = mode;
        i_req_tag = TAG_W'(tag); i_req_set = SW'(set);
    endtask

    task automatic rand_inputs();
        bit e;
        i_req_valid  = $urandom_range(0, 3) != 0;
        i_resp_ready = $urandom_range(0, 3) != 0;
        i_req_mode   = $urandom_range(0, 4) == 0;
        i_req_tag    = TAG_W'($urandom_range(1, 4));
        i_req_set    = SW'($urandom_range(0, 3));
        for (int w = 0; w < WAYS; w++) begin
            i_tags_in[w*TAG_W +: TAG_W] = TAG_W'($urandom_range(1, 6));
            e = $urandom_range(0, 9) == 0;
            for (int j = 0; j < WORDS; j++) set_word(w, j, e ? SPX_I : STATE_W'($urandom_range(0, 3)));
        end
    endtask

    task automatic mid_reset();
        i_req_valid = 1;
        #2 rst = 1'b0;
        #1;
        chk("async_rst_resp_valid", o_resp_valid, 0);
        chk("async_rst_req_ready", o_req_ready, 1);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        i_req_valid = 0;
        compare();
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_resp_valid", o_resp_valid, 0);
        chk("reset_req_ready", o_req_ready, 1);
        chk("reset_tag_hit", o_tag_hit, 0);
        chk("reset_evict_way", o_evict_way, 0);
        rst = 1'b1;
        for (int c = 0; c < 400; c++) begin
            rand_inputs();
            step();
            if (c == 200) mid_reset();
        end
        rand_inputs();
        i_resp_ready = 1'b1;
        mid_reset();
        // miss in full set 5 right after reset
        fill_full(); req(0, 32'h12345, 5); i_resp_ready = 1;
        step();
        chk("t1_evict_way", o_evict_way, 0);
        i_req_valid = 0; step();
        // hit in way 3 with words {R,S,I,V}
        fill_full();
        i_tags_in[3*TAG_W +: TAG_W] = TAG_W'(32'h1A5);
        set_word(3, 0, SPX_R); set_word(3, 1, SPX_S); set_word(3, 2, SPX_I); set_word(3, 3, SPX_V);
        req(0, 32'h1A5, 10);
        step();
        chk("t2_tag_hit", o_tag_hit, 1);
        chk("t2_way_hit", o_way_hit, 3);
        chk("t2_mask_owned", o_mask_owned, 4'b0001);
        chk("t2_mask_shared", o_mask_shared, 4'b0011);
        chk("t2_multi_hit", o_multi_hit, 0);
        i_req_valid = 0; step();
        // empty ways 2 and 6
        fill_full();
        for (int j = 0; j < WORDS; j++) begin set_word(2, j, SPX_I); set_word(6, j, SPX_I); end
        req(0, 32'h55, 11);
        step();
        chk("t3_empty_found", o_empty_found, 1);
        chk("t3_empty_way", o_empty_way, 2);
        chk("t3_evict_way", o_evict_way, 2);
        fill_full(); step();
        chk("t3_ptr_unchanged", o_evict_way, 0);
        i_req_valid = 0; step();
        // ten back-to-back misses to set 7
        fill_full(); req(0, 32'h99, 7);
        for (int k = 0; k < 10; k++) begin
            step();
            chk("t4_valid", o_resp_valid, 1);
            chk("t4_evict_way", o_evict_way, k % WAYS);
        end
        i_req_valid = 0; step();
        // backpressure on set 7 (pointer now 2)
        req(0, 32'h99, 7); step();
        chk("t5_first_evict", o_evict_way, 2);
        i_resp_ready = 0;
        for (int k = 0; k < 3; k++) begin
            i_tags_in[0 +: TAG_W] = TAG_W'($urandom);
            step();
            chk("t5_stall_ready", o_req_ready, 0);
            chk("t5_stall_evict", o_evict_way, 2);
        end
        fill_full(); i_resp_ready = 1; step();
        chk("t5_after_handoff", o_evict_way, 3);
        i_req_valid = 0; step();
        // forward with hits in ways 1 and 4
        fill_full();
        i_tags_in[1*TAG_W +: TAG_W] = TAG_W'(32'h777);
        i_tags_in[4*TAG_W +: TAG_W] = TAG_W'(32'h777);
        req(1, 32'h777, 7); step();
        chk("t6_tag_hit", o_tag_hit, 1);
        chk("t6_way_hit", o_way_hit, 1);
        chk("t6_multi_hit", o_multi_hit, 1);
        chk("t6_empty_found", o_empty_found, 0);
        chk("t6_evict_way", o_evict_way, 0);
        i_req_valid = 0; step();
        fill_full(); req(0, 32'h99, 7); step();
        chk("t6_ptr_unchanged", o_evict_way, 4);
        i_req_valid = 0; step();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
